// File: rtl/mdu_ctrl_pkg.sv
// Shared opcodes, FSM state type and sign helper for the multiply/divide unit.
package mdu_ctrl_pkg;

  typedef logic [2:0] mdu_op_t;

  localparam mdu_op_t MDU_MULT  = 3'd0;
  localparam mdu_op_t MDU_MULTU = 3'd1;
  localparam mdu_op_t MDU_DIV   = 3'd2;
  localparam mdu_op_t MDU_DIVU  = 3'd3;
  localparam mdu_op_t MDU_MTHI  = 3'd4;
  localparam mdu_op_t MDU_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MUL_WAIT = 2'd1,
    ST_DIV_RUN  = 2'd2,
    ST_DIV_FIX  = 2'd3
  } mdu_state_t;

  localparam logic [5:0] DIV_LAST_ITER = 6'd31;

  function automatic logic [31:0] cond_neg(input logic [31:0] v, input logic neg);
    return neg ? (32'd0 - v) : v;
  endfunction

endpackage

// File: rtl/mdu_ctrl_if.sv
// Issue/result bundle between the EX stage and the multiply/divide unit.
interface mdu_ctrl_if;
  import mdu_ctrl_pkg::*;

  logic        start;
  mdu_op_t     op;
  logic [31:0] da;
  logic [31:0] db;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (output start, op, da, db, flush, input busy, done, hi, lo);
  modport slave  (input start, op, da, db, flush, output busy, done, hi, lo);
endinterface

// File: rtl/mdu_ctrl_div_core.sv
// Unsigned 32-iteration restoring divider; one quotient bit per clock.
module div_core (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        done,
  output logic [31:0] quo,
  output logic [31:0] rem
);

  logic        run_q, run_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] dvs_q, dvs_d;
  logic        done_q, done_d;
  logic [32:0] part_s;
  logic [31:0] diff_s;
  logic        ge_s;

  // Next-state: load, iterate or abort.
  always_comb begin
    run_d  = run_q;
    cnt_d  = cnt_q;
    rem_d  = rem_q;
    quo_d  = quo_q;
    dvs_d  = dvs_q;
    done_d = 1'b0;
    // Partial remainder is 33 bits wide because rem < divisor can still overflow 32 bits once shifted.
    part_s = {rem_q, quo_q[31]};
    ge_s   = (part_s >= {1'b0, dvs_q});
    diff_s = part_s[31:0] - dvs_q;
    if (abort) begin
      run_d = 1'b0;
    end else if (start) begin
      run_d = 1'b1;
      cnt_d = 5'd0;
      rem_d = 32'd0;
      quo_d = dividend;
      dvs_d = divisor;
    end else if (run_q) begin
      if (ge_s) begin
        rem_d = diff_s;
        quo_d = {quo_q[30:0], 1'b1};
      end else begin
        rem_d = part_s[31:0];
        quo_d = {quo_q[30:0], 1'b0};
      end
      cnt_d = cnt_q + 5'd1;
      if (cnt_q == 5'd31) begin
        run_d  = 1'b0;
        done_d = 1'b1;
      end else begin
        run_d  = 1'b1;
      end
    end else begin
      run_d = run_q;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      run_q  <= 1'b0;
      cnt_q  <= 5'd0;
      rem_q  <= 32'd0;
      quo_q  <= 32'd0;
      dvs_q  <= 32'd0;
      done_q <= 1'b0;
    end else begin
      run_q  <= run_d;
      cnt_q  <= cnt_d;
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      dvs_q  <= dvs_d;
      done_q <= done_d;
    end
  end

  assign done = done_q;
  assign quo  = quo_q;
  assign rem  = rem_q;

endmodule

// File: rtl/mdu_ctrl.sv
// MIPS multiply/divide controller: sequences MULT/DIV, owns HI/LO, raises busy for decode stalls.
module mdu_ctrl
  import mdu_ctrl_pkg::*;
#(
  parameter int MUL_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  mdu_ctrl_if.slave  bus
);

  localparam logic [5:0] MUL_LAST = 6'(MUL_CYCLES);

  mdu_state_t  state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [63:0] prod_q, prod_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        done_q, done_d;
  logic        busy_q, busy_d;
  logic        qsign_q, qsign_d;
  logic        rsign_q, rsign_d;

  logic        sdiv_s, smul_s, div_start_s, div_done_s;
  logic [63:0] ma_s, mb_s;
  logic [31:0] dvd_s, dvs_s, quo_s, rem_s;

  div_core u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start_s),
    .abort    (bus.flush),
    .dividend (dvd_s),
    .divisor  (dvs_s),
    .done     (div_done_s),
    .quo      (quo_s),
    .rem      (rem_s)
  );

  // FSM next-state and HI/LO update.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    prod_d      = prod_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    done_d      = 1'b0;
    qsign_d     = qsign_q;
    rsign_d     = rsign_q;
    div_start_s = 1'b0;
    sdiv_s      = (bus.op == MDU_DIV);
    smul_s      = (bus.op == MDU_MULT);
    // Extending to 64 bits first lets one unsigned multiply serve both signednesses.
    ma_s        = {{32{smul_s & bus.da[31]}}, bus.da};
    mb_s        = {{32{smul_s & bus.db[31]}}, bus.db};
    dvd_s       = cond_neg(bus.da, sdiv_s & bus.da[31]);
    dvs_s       = cond_neg(bus.db, sdiv_s & bus.db[31]);
    case (state_q)
      ST_IDLE: begin
        if (bus.flush) begin
          state_d = ST_IDLE;
        end else if (bus.start) begin
          case (bus.op)
            MDU_MULT, MDU_MULTU: begin
              prod_d  = ma_s * mb_s;
              cnt_d   = 6'd1;
              state_d = ST_MUL_WAIT;
            end
            MDU_DIV, MDU_DIVU: begin
              if (bus.db == 32'd0) begin
                lo_d   = 32'hFFFF_FFFF;
                hi_d   = bus.da;
                done_d = 1'b1;
              end else begin
                qsign_d     = sdiv_s & (bus.da[31] ^ bus.db[31]);
                rsign_d     = sdiv_s & bus.da[31];
                div_start_s = 1'b1;
                cnt_d       = 6'd0;
                state_d     = ST_DIV_RUN;
              end
            end
            MDU_MTHI: begin
              hi_d   = bus.da;
              done_d = 1'b1;
            end
            MDU_MTLO: begin
              lo_d   = bus.da;
              done_d = 1'b1;
            end
            default: state_d = ST_IDLE;
          endcase
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_MUL_WAIT: begin
        if (bus.flush) begin
          state_d = ST_IDLE;
        end else if (cnt_q == MUL_LAST) begin
          {hi_d, lo_d} = prod_q;
          done_d       = 1'b1;
          state_d      = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
      end
      ST_DIV_RUN: begin
        if (bus.flush) begin
          state_d = ST_IDLE;
        end else if (cnt_q == DIV_LAST_ITER) begin
          state_d = ST_DIV_FIX;
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
      end
      ST_DIV_FIX: begin
        if (bus.flush) begin
          state_d = ST_IDLE;
        end else if (div_done_s) begin
          lo_d    = cond_neg(quo_s, qsign_q);
          hi_d    = cond_neg(rem_s, rsign_q);
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DIV_FIX;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // Architectural and control registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 6'd0;
      prod_q  <= 64'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      qsign_q <= 1'b0;
      rsign_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      qsign_q <= qsign_d;
      rsign_q <= rsign_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: directed table, corner sequences, random ops vs. arithmetic model.
module tb_mdu_ctrl;
  import mdu_ctrl_pkg::*;

  localparam int MC = 2;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] da;
    logic [31:0] db;
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  logic [31:0] m_hi, m_lo, ah, al, sv_hi, sv_lo;
  int          alat, nbusy, elat;
  bit          bad_pulse, fires, seen;
  logic [2:0]  rop;
  logic [31:0] ra, rb;
  vec_t        vecs[9];

  mdu_ctrl_if bus();

  mdu_ctrl #(.MUL_CYCLES(MC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Architectural model: plain arithmetic on the MIPS rules.
  task automatic ref_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        inout logic [31:0] h, inout logic [31:0] l,
                        output int lat, output bit fire);
    longint          sp;
    longint unsigned up;
    int              ia, ib;
    fire = 1'b1;
    lat  = 0;
    case (op)
      MDU_MULT: begin
        sp = longint'($signed(a)) * longint'($signed(b));
        h = sp[63:32]; l = sp[31:0]; lat = MC;
      end
      MDU_MULTU: begin
        up = {32'd0, a};
        up = up * {32'd0, b};
        h = up[63:32]; l = up[31:0]; lat = MC;
      end
      MDU_DIV, MDU_DIVU: begin
        if (b == 32'd0) begin
          l = 32'hFFFF_FFFF; h = a;
        end else begin
          lat = 33;
          if (op == MDU_DIVU) begin
            l = a / b; h = a % b;
          end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            l = 32'h8000_0000; h = 32'd0;
          end else begin
            ia = a; ib = b;
            l = ia / ib; h = ia % ib;
          end
        end
      end
      MDU_MTHI: h = a;
      MDU_MTLO: l = a;
      default:  fire = 1'b0;
    endcase
  endtask

  // Issue one op and watch done/busy, sampling 1 time unit after each rising edge.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int limit, output int lat_o, output int nb,
                        output logic [31:0] h, output logic [31:0] l, output bit badp);
    @(negedge clk);
    bus.op = op; bus.da = a; bus.db = b; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat_o = -1; nb = 0; badp = 1'b0;
    for (int k = 0; k <= limit; k++) begin
      if (bus.busy) nb++;
      if (bus.done && bus.busy) badp = 1'b1;
      if (bus.done) begin
        lat_o = k;
        break;
      end
      @(posedge clk); #1;
    end
    h = bus.hi; l = bus.lo;
    if (lat_o >= 0) begin
      @(posedge clk); #1;
      if (bus.done) badp = 1'b1;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; bus.start = 1'b0; bus.op = 3'd0; bus.da = 32'd0; bus.db = 32'd0; bus.flush = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {63'd0, bus.busy}, 64'd0);
    chk("rst_done", {63'd0, bus.done}, 64'd0);
    chk("rst_hi", {32'd0, bus.hi}, 64'd0);
    chk("rst_lo", {32'd0, bus.lo}, 64'd0);
    @(negedge clk) rst = 1'b0;
    m_hi = 32'd0; m_lo = 32'd0;

    vecs[0] = '{MDU_MULT,  32'hFFFF_FFFD, 32'd7,        32'hFFFF_FFFF, 32'hFFFF_FFEB, MC};
    vecs[1] = '{MDU_MULTU, 32'hFFFF_FFFF, 32'd2,        32'h0000_0001, 32'hFFFF_FFFE, MC};
    vecs[2] = '{MDU_DIV,   32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 33};
    vecs[3] = '{MDU_DIVU,  32'd100,       32'd7,        32'h0000_0002, 32'h0000_000E, 33};
    vecs[4] = '{MDU_DIVU,  32'h1234,      32'd0,        32'h0000_1234, 32'hFFFF_FFFF, 0};
    vecs[5] = '{MDU_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        32'h8000_0000, 33};
    vecs[6] = '{MDU_MTHI,  32'hCAFE,      32'd0,        32'h0000_CAFE, 32'h8000_0000, 0};
    vecs[7] = '{MDU_MTLO,  32'hBEEF,      32'd0,        32'h0000_CAFE, 32'h0000_BEEF, 0};
    vecs[8] = '{MDU_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,        32'hFFFF_FFFD, 33};

    for (int i = 0; i < 9; i++) begin
      run_op(vecs[i].op, vecs[i].da, vecs[i].db, 40, alat, nbusy, ah, al, bad_pulse);
      chk($sformatf("vec%0d_hi", i), {32'd0, ah}, {32'd0, vecs[i].hi});
      chk($sformatf("vec%0d_lo", i), {32'd0, al}, {32'd0, vecs[i].lo});
      chk($sformatf("vec%0d_lat", i), 64'(alat), 64'(vecs[i].lat));
      chk($sformatf("vec%0d_busycyc", i), 64'(nbusy), 64'(vecs[i].lat));
      chk($sformatf("vec%0d_pulse", i), {63'd0, bad_pulse}, 64'd0);
      m_hi = vecs[i].hi; m_lo = vecs[i].lo;
    end

    // MTHI and MTLO on consecutive edges.
    @(negedge clk);
    bus.start = 1'b1; bus.op = MDU_MTHI; bus.da = 32'h1111_CAFE;
    @(posedge clk); #1;
    chk("b2b_done1", {63'd0, bus.done}, 64'd1);
    bus.op = MDU_MTLO; bus.da = 32'h2222_BEEF;
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("b2b_done2", {63'd0, bus.done}, 64'd1);
    chk("b2b_hi", {32'd0, bus.hi}, 64'h1111_CAFE);
    chk("b2b_lo", {32'd0, bus.lo}, 64'h2222_BEEF);
    m_hi = 32'h1111_CAFE; m_lo = 32'h2222_BEEF;

    // Start held high with a different op while busy must be ignored.
    @(negedge clk);
    bus.start = 1'b1; bus.op = MDU_DIVU; bus.da = 32'd100; bus.db = 32'd7;
    @(posedge clk); #1;
    bus.op = MDU_MTHI; bus.da = 32'hDEAD_DEAD; bus.db = 32'd0;
    alat = -1;
    for (int k = 0; k <= 40; k++) begin
      if (bus.done) begin
        alat = k;
        break;
      end
      @(posedge clk); #1;
    end
    bus.start = 1'b0;
    chk("hold_lat", 64'(alat), 64'd33);
    chk("hold_hi", {32'd0, bus.hi}, 64'd2);
    chk("hold_lo", {32'd0, bus.lo}, 64'hE);
    m_hi = 32'd2; m_lo = 32'hE;

    // Flush sampled ten edges into a divide.
    @(negedge clk);
    bus.start = 1'b1; bus.op = MDU_DIV; bus.da = 32'd1000; bus.db = 32'd3;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("fl10_busy_before", {63'd0, bus.busy}, 64'd1);
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    chk("fl10_busy", {63'd0, bus.busy}, 64'd0);
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (bus.done || bus.busy) seen = 1'b1;
      @(posedge clk); #1;
    end
    chk("fl10_nodone", {63'd0, seen}, 64'd0);
    chk("fl10_hi", {32'd0, bus.hi}, {32'd0, m_hi});
    chk("fl10_lo", {32'd0, bus.lo}, {32'd0, m_lo});

    // Flush on the multiply completion edge wins.
    @(negedge clk);
    bus.start = 1'b1; bus.op = MDU_MULTU; bus.da = 32'hFFFF_FFFF; bus.db = 32'd3;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (MC - 1) @(posedge clk);
    #1;
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    chk("flmul_busy", {63'd0, bus.busy}, 64'd0);
    chk("flmul_done", {63'd0, bus.done}, 64'd0);
    chk("flmul_hi", {32'd0, bus.hi}, {32'd0, m_hi});
    chk("flmul_lo", {32'd0, bus.lo}, {32'd0, m_lo});

    // Flush on the divide sign-fix edge wins.
    @(negedge clk);
    bus.start = 1'b1; bus.op = MDU_DIV; bus.da = 32'hFFFF_FF00; bus.db = 32'd5;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (32) @(posedge clk);
    #1;
    chk("flfix_busy_before", {63'd0, bus.busy}, 64'd1);
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    chk("flfix_done", {63'd0, bus.done}, 64'd0);
    chk("flfix_busy", {63'd0, bus.busy}, 64'd0);
    chk("flfix_lo", {32'd0, bus.lo}, {32'd0, m_lo});

    // Flush together with start in IDLE drops the start.
    @(negedge clk);
    bus.start = 1'b1; bus.flush = 1'b1; bus.op = MDU_MTHI; bus.da = 32'h5555_5555;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.flush = 1'b0;
    chk("flidle_done", {63'd0, bus.done}, 64'd0);
    chk("flidle_hi", {32'd0, bus.hi}, {32'd0, m_hi});

    // Reset ten edges into a divide clears everything.
    @(negedge clk);
    bus.start = 1'b1; bus.op = MDU_DIVU; bus.da = 32'd999; bus.db = 32'd4;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst10_busy", {63'd0, bus.busy}, 64'd0);
    chk("rst10_done", {63'd0, bus.done}, 64'd0);
    chk("rst10_hi", {32'd0, bus.hi}, 64'd0);
    chk("rst10_lo", {32'd0, bus.lo}, 64'd0);
    m_hi = 32'd0; m_lo = 32'd0;
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (bus.done) seen = 1'b1;
      @(posedge clk); #1;
    end
    chk("rst10_nodone", {63'd0, seen}, 64'd0);

    // Random ops against the arithmetic model.
    for (int i = 0; i < 40; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      case ($urandom_range(0, 4))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 20));
        2:       rb = 32'hFFFF_FFFF;
        3:       rb = 32'h8000_0000 | 32'($urandom_range(0, 7));
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 5) == 0) ra = 32'h8000_0000;
      sv_hi = m_hi; sv_lo = m_lo;
      ref_op(rop, ra, rb, m_hi, m_lo, elat, fires);
      run_op(rop, ra, rb, fires ? 40 : 5, alat, nbusy, ah, al, bad_pulse);
      chk($sformatf("rnd%0d_op%0d_hi", i, rop), {32'd0, ah}, {32'd0, m_hi});
      chk($sformatf("rnd%0d_op%0d_lo", i, rop), {32'd0, al}, {32'd0, m_lo});
      chk($sformatf("rnd%0d_op%0d_lat", i, rop), 64'(alat), fires ? 64'(elat) : 64'hFFFF_FFFF_FFFF_FFFF);
      chk($sformatf("rnd%0d_op%0d_busycyc", i, rop), 64'(nbusy), fires ? 64'(elat) : 64'd0);
      chk($sformatf("rnd%0d_op%0d_pulse", i, rop), {63'd0, bad_pulse}, 64'd0);
      if (!fires) begin
        chk($sformatf("rnd%0d_undef_keep", i), {bus.hi, bus.lo}, {sv_hi, sv_lo});
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
